// File: rtl/four_step_pkg.sv
// Shared types and constants for the four-step commutation monitor.
package four_step_pkg;

  // Group masks for buses up to 64 bits; users slice to their width.
  localparam logic [63:0] MASK_A_ALL = {32{2'b01}};
  localparam logic [63:0] MASK_B_ALL = {32{2'b10}};
  localparam logic [5:0]  MASK_A     = 6'b010101;
  localparam logic [5:0]  MASK_B     = 6'b101010;

  typedef enum logic [1:0] {IDLE, PH, RESYNC} state_t;

  typedef enum logic [2:0] {P0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3, P4 = 3'd4} phase_t;

  typedef enum logic [2:0] {NONE, ON_A, OFF_A, ON_B, OFF_B, ILLEGAL} kind_t;

  typedef enum logic {GRP_A = 1'b0, GRP_B = 1'b1} grp_t;

endpackage

// File: rtl/four_step_monitor_if.sv
// Observation bus between the four-step gate driver side and the monitor.
interface four_step_monitor_if #(
  parameter int W = 6
);
  logic [W-1:0] vin;
  logic         err_clr;
  logic [W-1:0] vstable;
  logic         seq_done;
  logic         seq_dir;
  logic         busy;
  logic         err_illegal;
  logic         err_order;
  logic [15:0]  seq_count;

  modport master (
    output vin, err_clr,
    input  vstable, seq_done, seq_dir, busy, err_illegal, err_order, seq_count
  );

  modport slave (
    input  vin, err_clr,
    output vstable, seq_done, seq_dir, busy, err_illegal, err_order, seq_count
  );
endinterface

// File: rtl/four_step_classify.sv
// Combinational classifier: kind of change between two consecutive gate samples.
module four_step_classify
  import four_step_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] vprev,
  input  logic [W-1:0] vin,
  output kind_t        kind
);
  localparam logic [W-1:0] GA = MASK_A_ALL[W-1:0];
  localparam logic [W-1:0] GB = MASK_B_ALL[W-1:0];

  logic [W-1:0] d;
  logic         all_on;
  logic         all_off;

  always_comb begin
    d       = vin ^ vprev;
    all_on  = ((vin & d) == d);
    all_off = ((vin & d) == '0);
    kind    = ILLEGAL;
    if (d == '0) begin
      kind = NONE;
    end else if ((d & ~GA) == '0) begin
      if (all_on)       kind = ON_A;
      else if (all_off) kind = OFF_A;
    end else if ((d & ~GB) == '0) begin
      if (all_on)       kind = ON_B;
      else if (all_off) kind = OFF_B;
    end
  end

endmodule

// File: rtl/four_step_monitor.sv
// Passive checker/decoder for the four-step commutation gate bus.
module four_step_monitor
  import four_step_pkg::*;
#(
  parameter int             W          = 6,
  parameter logic [W-1:0]   INIT_VEC   = 6'b000011,
  parameter int             STABLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  four_step_monitor_if.slave bus
);
  localparam int            CW          = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);

  state_t        state, state_n;
  phase_t        k, k_n, j;
  grp_t          m, m_n, kgrp;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  vprev, vstable, vstable_n;
  logic          seq_done, seq_done_n, seq_dir, seq_dir_n;
  logic          err_illegal, err_order, ill_set, ord_set, kon;
  logic [15:0]   seq_count, seq_count_n;
  kind_t         kind;

  four_step_classify #(.W(W)) u_classify (
    .vprev (vprev),
    .vin   (bus.vin),
    .kind  (kind)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= P0;
      m           <= GRP_A;
      cnt         <= '0;
      vprev       <= INIT_VEC;
      vstable     <= INIT_VEC;
      seq_done    <= 1'b0;
      seq_dir     <= 1'b0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      seq_count   <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      m           <= m_n;
      cnt         <= cnt_n;
      vprev       <= bus.vin;
      vstable     <= vstable_n;
      seq_done    <= seq_done_n;
      seq_dir     <= seq_dir_n;
      // A fresh error outranks a simultaneous clear.
      err_illegal <= (err_illegal & ~bus.err_clr) | ill_set;
      err_order   <= (err_order & ~bus.err_clr) | ord_set;
      seq_count   <= seq_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    k_n         = k;
    m_n         = m;
    cnt_n       = cnt;
    vstable_n   = vstable;
    seq_done_n  = 1'b0;
    seq_dir_n   = seq_dir;
    seq_count_n = seq_count;
    ill_set     = 1'b0;
    ord_set     = 1'b0;
    kgrp        = (kind == ON_B || kind == OFF_B) ? GRP_B : GRP_A;
    kon         = (kind == ON_A || kind == ON_B);
    // Phase of this change relative to the first-switched group M.
    if (kgrp == m) j = kon ? P2 : P3;
    else           j = kon ? P4 : P1;

    case (state)
      IDLE: begin
        if (kind == ILLEGAL) begin
          ill_set = 1'b1;
          state_n = RESYNC;
          cnt_n   = '0;
        end else if (kind != NONE) begin
          state_n = PH;
          cnt_n   = '0;
          if (kon) begin
            k_n = P2;
            m_n = kgrp;
          end else begin
            k_n = P1;
            m_n = (kgrp == GRP_A) ? GRP_B : GRP_A;
          end
        end
      end
      PH: begin
        if (kind == ILLEGAL) begin
          ill_set = 1'b1;
          state_n = RESYNC;
          cnt_n   = '0;
        end else if (kind == NONE) begin
          if (cnt == STABLE_LAST) begin
            vstable_n   = bus.vin;
            seq_dir_n   = (m == GRP_A);
            seq_done_n  = 1'b1;
            seq_count_n = (seq_count == 16'hFFFF) ? seq_count : seq_count + 16'd1;
            state_n     = IDLE;
            cnt_n       = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (j > k) begin
          k_n   = j;
          cnt_n = '0;
        end else begin
          ord_set = 1'b1;
          state_n = RESYNC;
          cnt_n   = '0;
        end
      end
      RESYNC: begin
        if (kind != NONE) begin
          cnt_n = '0;
        end else if (cnt == STABLE_LAST) begin
          vstable_n = bus.vin;
          state_n   = IDLE;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.vstable     = vstable;
  assign bus.seq_done    = seq_done;
  assign bus.seq_dir     = seq_dir;
  assign bus.busy        = (state != IDLE);
  assign bus.err_illegal = err_illegal;
  assign bus.err_order   = err_order;
  assign bus.seq_count   = seq_count;

endmodule

// File: tb/tb_four_step_monitor.sv
// Directed self-checking bench for four_step_monitor.
module tb_four_step_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;

  four_step_monitor_if #(.W(6)) bus ();

  four_step_monitor #(.W(6), .INIT_VEC(6'b000011), .STABLE_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.seq_done === 1'b1) pulses++;

  task automatic drive(input logic [5:0] v);
    @(posedge clk); #1 bus.vin = v;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bus.vin = 6'b000011; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.vstable !== 6'b000011) begin miscompares++; $display("FAIL reset vstable got %b want 000011", bus.vstable); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", bus.busy); end
    vectors++; if (bus.err_illegal !== 1'b0 || bus.err_order !== 1'b0) begin miscompares++; $display("FAIL reset errs got %b%b want 00", bus.err_illegal, bus.err_order); end
    vectors++; if (bus.seq_count !== 16'd0) begin miscompares++; $display("FAIL reset count got %0d want 0", bus.seq_count); end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL reset pulses got %0d want 0", pulses); end
  endtask

  task automatic test_seq_a(input logic [15:0] exp_count);
    int p0 = pulses;
    drive(6'b000001);
    drive(6'b000101);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL seqA busy got %b want 1", bus.busy); end
    drive(6'b000100);
    drive(6'b001100);
    settle();
    vectors++; if (pulses !== p0 + 1) begin miscompares++; $display("FAIL seqA pulses got %0d want %0d", pulses - p0, 1); end
    vectors++; if (bus.vstable !== 6'b001100) begin miscompares++; $display("FAIL seqA vstable got %b want 001100", bus.vstable); end
    vectors++; if (bus.seq_dir !== 1'b1) begin miscompares++; $display("FAIL seqA dir got %b want 1", bus.seq_dir); end
    vectors++; if (bus.seq_count !== exp_count) begin miscompares++; $display("FAIL seqA count got %0d want %0d", bus.seq_count, exp_count); end
    vectors++; if (bus.busy !== 1'b0 || bus.err_illegal !== 1'b0 || bus.err_order !== 1'b0) begin miscompares++; $display("FAIL seqA idle/errs got %b%b%b want 000", bus.busy, bus.err_illegal, bus.err_order); end
  endtask

  task automatic test_seq_b();
    int p0 = pulses;
    drive(6'b001000);
    drive(6'b101000);
    drive(6'b100000);
    drive(6'b110000);
    settle();
    vectors++; if (pulses !== p0 + 1) begin miscompares++; $display("FAIL seqB pulses got %0d want 1", pulses - p0); end
    vectors++; if (bus.vstable !== 6'b110000) begin miscompares++; $display("FAIL seqB vstable got %b want 110000", bus.vstable); end
    vectors++; if (bus.seq_dir !== 1'b0) begin miscompares++; $display("FAIL seqB dir got %b want 0", bus.seq_dir); end
    vectors++; if (bus.seq_count !== 16'd2) begin miscompares++; $display("FAIL seqB count got %0d want 2", bus.seq_count); end
  endtask

  task automatic test_illegal();
    int p0 = pulses;
    drive(6'b000011);
    settle();
    vectors++; if (bus.err_illegal !== 1'b1) begin miscompares++; $display("FAIL ill1 flag got %b want 1", bus.err_illegal); end
    vectors++; if (bus.vstable !== 6'b000011) begin miscompares++; $display("FAIL ill1 vstable got %b want 000011", bus.vstable); end
    drive(6'b001100);
    bus.err_clr = 1'b1;
    @(posedge clk); #1 bus.err_clr = 1'b0;
    vectors++; if (bus.err_illegal !== 1'b1) begin miscompares++; $display("FAIL ill_vs_clr flag got %b want 1", bus.err_illegal); end
    settle();
    vectors++; if (bus.vstable !== 6'b001100) begin miscompares++; $display("FAIL ill2 vstable got %b want 001100", bus.vstable); end
    vectors++; if (bus.seq_count !== 16'd2) begin miscompares++; $display("FAIL ill2 count got %0d want 2", bus.seq_count); end
    vectors++; if (pulses !== p0) begin miscompares++; $display("FAIL ill2 pulses got %0d want 0", pulses - p0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ill2 busy got %b want 0", bus.busy); end
    clr_pulse();
    vectors++; if (bus.err_illegal !== 1'b0) begin miscompares++; $display("FAIL ill_clr flag got %b want 0", bus.err_illegal); end
  endtask

  task automatic test_order();
    int p0;
    do_reset();
    p0 = pulses;
    drive(6'b000001);
    drive(6'b000000);
    drive(6'b000100);
    vectors++; if (bus.err_order !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL ord_pre order/busy got %b%b want 01", bus.err_order, bus.busy); end
    settle();
    vectors++; if (bus.err_order !== 1'b1) begin miscompares++; $display("FAIL ord flag got %b want 1", bus.err_order); end
    vectors++; if (bus.err_illegal !== 1'b0) begin miscompares++; $display("FAIL ord illegal got %b want 0", bus.err_illegal); end
    vectors++; if (bus.vstable !== 6'b000100) begin miscompares++; $display("FAIL ord vstable got %b want 000100", bus.vstable); end
    vectors++; if (pulses !== p0 || bus.seq_count !== 16'd0) begin miscompares++; $display("FAIL ord pulses/count got %0d/%0d want 0/0", pulses - p0, bus.seq_count); end
    clr_pulse();
    vectors++; if (bus.err_order !== 1'b0) begin miscompares++; $display("FAIL ord_clr flag got %b want 0", bus.err_order); end
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    p0 = pulses;
    drive(6'b000001);
    drive(6'b000101);
    @(posedge clk); #1 rst_n = 1'b0; bus.vin = 6'b000011;
    @(posedge clk); #1 rst_n = 1'b1;
    vectors++; if (bus.vstable !== 6'b000011) begin miscompares++; $display("FAIL rstmid vstable got %b want 000011", bus.vstable); end
    vectors++; if (bus.busy !== 1'b0 || bus.seq_count !== 16'd0) begin miscompares++; $display("FAIL rstmid busy/count got %b/%0d want 0/0", bus.busy, bus.seq_count); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (pulses !== p0) begin miscompares++; $display("FAIL rstmid pulses got %0d want 0", pulses - p0); end
    test_seq_a(16'd1);
  endtask

  task automatic test_skip_early();
    int p0;
    do_reset();
    p0 = pulses;
    drive(6'b000111);
    drive(6'b001111);
    settle();
    vectors++; if (bus.vstable !== 6'b001111 || bus.seq_dir !== 1'b1) begin miscompares++; $display("FAIL skip vstable/dir got %b/%b want 001111/1", bus.vstable, bus.seq_dir); end
    drive(6'b001011);
    settle();
    vectors++; if (bus.vstable !== 6'b001011 || bus.seq_dir !== 1'b0) begin miscompares++; $display("FAIL early vstable/dir got %b/%b want 001011/0", bus.vstable, bus.seq_dir); end
    vectors++; if (bus.seq_count !== 16'd2 || pulses !== p0 + 2) begin miscompares++; $display("FAIL early count/pulses got %0d/%0d want 2/2", bus.seq_count, pulses - p0); end
  endtask

  task automatic test_k4_change();
    int p0;
    do_reset();
    p0 = pulses;
    drive(6'b000111);
    drive(6'b001111);
    drive(6'b001011);
    settle();
    vectors++; if (bus.err_order !== 1'b1) begin miscompares++; $display("FAIL k4 order got %b want 1", bus.err_order); end
    vectors++; if (bus.vstable !== 6'b001011) begin miscompares++; $display("FAIL k4 vstable got %b want 001011", bus.vstable); end
    vectors++; if (bus.seq_count !== 16'd0 || pulses !== p0) begin miscompares++; $display("FAIL k4 count/pulses got %0d/%0d want 0/0", bus.seq_count, pulses - p0); end
  endtask

  initial begin
    bus.vin = 6'b000011;
    bus.err_clr = 1'b0;
    test_reset();
    test_seq_a(16'd1);
    test_seq_b();
    test_illegal();
    test_order();
    test_reset_mid();
    test_skip_early();
    test_k4_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
